// File: rtl/l2_arbiter.sv
// Purpose: shares the single L2 block port between the I-L1 and D-L1 miss paths.
// Latency: the L2 request appears 1 cycle after grant; the ready pulse appears 1 cycle after l2_ready is seen.
// Backpressure: each requester holds its request until its ready pulse; l2_ready low stalls both sides indefinitely.
module l2_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [DATA_W-1:0] l2_wdata,
    input  logic [DATA_W-1:0] l2_rdata,
    input  logic              l2_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Grant encoding for gnt / last_grant.
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    logic [1:0] state;
    logic       gnt;
    logic       last_grant;
    logic       i_req;
    logic       d_req;
    logic       pick_d;

    // Request decode and grant choice; D wins ties unless round-robin says it is I's turn.
    always_comb begin
        i_req  = i_read;
        d_req  = d_read | d_write;
        pick_d = 1'b0;
        if (d_req) begin
            if (!i_req) begin
                pick_d = 1'b1;
            end else if (RR_EN != 0) begin
                pick_d = (last_grant == GNT_I);
            end else begin
                pick_d = 1'b1;
            end
        end
    end

    // Arbitration FSM: grant and latch in IDLE, hold until l2_ready in BUSY,
    // then wait out any stretched l2_ready in DRAIN so it cannot complete the next request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            gnt        <= GNT_I;
            last_grant <= GNT_I;
            l2_read    <= 1'b0;
            l2_write   <= 1'b0;
            l2_addr    <= '0;
            l2_wdata   <= '0;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    if (i_req || d_req) begin
                        if (pick_d) begin
                            // Write-back takes precedence when read and write are both raised.
                            l2_write   <= d_write;
                            l2_read    <= ~d_write;
                            l2_addr    <= d_addr;
                            l2_wdata   <= d_wdata;
                            gnt        <= GNT_D;
                            last_grant <= GNT_D;
                        end else begin
                            l2_write   <= 1'b0;
                            l2_read    <= 1'b1;
                            l2_addr    <= i_addr;
                            l2_wdata   <= '0;
                            gnt        <= GNT_I;
                            last_grant <= GNT_I;
                        end
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (l2_ready) begin
                        if (gnt == GNT_D) begin
                            d_rdata <= l2_rdata;
                            d_ready <= 1'b1;
                        end else begin
                            i_rdata <= l2_rdata;
                            i_ready <= 1'b1;
                        end
                        l2_read  <= 1'b0;
                        l2_write <= 1'b0;
                        state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    if (!l2_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    l2_read  <= 1'b0;
                    l2_write <= 1'b0;
                    i_ready  <= 1'b0;
                    d_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Purpose: directed bench for l2_arbiter with request/response scoreboards and a fixed-priority instance.
// Latency: expectations are queued by stimulus and popped by a negedge monitor when the DUT presents them.
// Backpressure: the bench plays the L2 with programmable latency and l2_ready hold length.
module tb_l2_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic          side;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] l2_rdata = '0;
    logic          l2_ready = 1'b0;
    logic [DW-1:0] i_rdata, d_rdata, l2_wdata;
    logic          i_ready, d_ready, l2_read, l2_write;
    logic [AW-1:0] l2_addr;

    // Fixed-priority instance: own handshake inputs, shared address/data.
    logic          fp_i_read = 1'b0;
    logic          fp_d_read = 1'b0;
    logic          fp_d_write = 1'b0;
    logic          fp_l2_ready = 1'b0;
    logic [DW-1:0] fp_i_rdata, fp_d_rdata, fp_l2_wdata;
    logic          fp_i_ready, fp_d_ready, fp_l2_read, fp_l2_write;
    logic [AW-1:0] fp_l2_addr;

    int   checks = 0;
    int   errors = 0;
    req_t req_q[$];
    rsp_t rsp_q[$];
    req_t mon_cur, mon_snap, mon_exp;
    rsp_t rsp_exp, rsp_got;
    logic mon_prev = 1'b0;

    always #5 clk = ~clk;

    l2_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_ready(l2_ready)
    );

    l2_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(0)) dut_fp (
        .clk(clk), .reset(reset),
        .i_read(fp_i_read), .i_addr(i_addr), .i_rdata(fp_i_rdata), .i_ready(fp_i_ready),
        .d_read(fp_d_read), .d_write(fp_d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(fp_d_rdata), .d_ready(fp_d_ready),
        .l2_read(fp_l2_read), .l2_write(fp_l2_write), .l2_addr(fp_l2_addr), .l2_wdata(fp_l2_wdata),
        .l2_rdata(l2_rdata), .l2_ready(fp_l2_ready)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic side);
        if (side == SIDE_D) req_q.push_back('{rd: ~d_write, wr: d_write, addr: d_addr, wdata: d_wdata});
        else                req_q.push_back('{rd: 1'b1, wr: 1'b0, addr: i_addr, wdata: '0});
    endtask

    // Acts as the L2: wait for a request, respond after lat cycles, hold l2_ready for hold cycles.
    task automatic serve(input logic side, input int lat, input int hold,
                         input logic [DW-1:0] data, input logic drop);
        int n = 0;
        while (!(l2_read | l2_write) && n < 50) begin
            tick;
            n++;
        end
        if (n == 50) check("l2_req_timeout", 1, 0);
        repeat (lat) tick;
        l2_rdata = data;
        l2_ready = 1'b1;
        rsp_q.push_back('{side: side, data: data});
        tick;
        if (drop) begin
            if (side == SIDE_D) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end else begin
                i_read = 1'b0;
            end
        end
        repeat (hold - 1) tick;
        l2_ready = 1'b0;
    endtask

    // Monitor: match each new L2 request and each ready pulse against the scoreboards.
    always @(negedge clk) begin
        mon_cur = '{rd: l2_read, wr: l2_write, addr: l2_addr, wdata: l2_wdata};
        if ((l2_read | l2_write) && !mon_prev) begin
            if (req_q.size() == 0) begin
                check("l2_req_unexpected", {l2_read, l2_write}, 0);
            end else begin
                mon_exp = req_q.pop_front();
                check("l2_req", mon_cur, mon_exp);
            end
            mon_snap = mon_cur;
        end else if ((l2_read | l2_write) && mon_prev) begin
            check("l2_hold", mon_cur, mon_snap);
        end
        mon_prev = l2_read | l2_write;
        if (i_ready && d_ready) check("ready_both", 1, 0);
        if (i_ready || d_ready) begin
            rsp_got = '{side: d_ready, data: (d_ready ? d_rdata : i_rdata)};
            if (rsp_q.size() == 0) begin
                check("ready_unexpected", {i_ready, d_ready}, 0);
            end else begin
                rsp_exp = rsp_q.pop_front();
                check("ready_rsp", rsp_got, rsp_exp);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] a5;
        logic [31:0]   w;
        int            n;
        a5 = {16{8'hA5}};

        // Reset held with a pending I request, then a lone I read.
        reset  = 1'b0;
        i_read = 1'b1;
        i_addr = 28'h0000123;
        repeat (2) begin
            tick;
            check("rst_ctrl", {l2_read, l2_write, i_ready, d_ready}, 0);
            check("rst_addr", l2_addr, 0);
            check("rst_wdata", l2_wdata, 0);
            check("rst_rdata", {i_rdata, d_rdata}, 0);
        end
        push_req(SIDE_I);
        reset = 1'b1;
        check("rel_cyc1_l2_read", l2_read, 0);
        tick;
        check("rel_cyc2_l2_read", l2_read, 1);
        check("rel_cyc2_l2_addr", l2_addr, 28'h0000123);
        serve(SIDE_I, 6, 1, a5, 1'b1);
        check("lone_i_rdata", i_rdata, a5);
        check("lone_i_ready", {i_ready, d_ready}, 2'b10);
        tick;
        check("lone_i_ready_fall", i_ready, 0);
        repeat (3) tick;

        // Simultaneous I read and D read+write straight out of reset: D write first.
        reset   = 1'b0;
        i_read  = 1'b1;
        i_addr  = 28'h00ABCDE;
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 28'h0FEDCBA;
        d_wdata = {4{32'hDEAD0001}};
        tick;
        reset = 1'b1;
        push_req(SIDE_D);
        push_req(SIDE_I);
        serve(SIDE_D, 2, 1, {4{32'h0D0D0002}}, 1'b1);
        serve(SIDE_I, 3, 1, {4{32'h11110003}}, 1'b1);
        tick;
        check("d_rdata_kept", d_rdata, {4{32'h0D0D0002}});
        check("i_rdata_new", i_rdata, {4{32'h11110003}});
        repeat (2) tick;

        // Stretched l2_ready with i_read held: one pulse, re-grant only after l2_ready falls.
        i_read = 1'b1;
        i_addr = 28'h0044444;
        push_req(SIDE_I);
        push_req(SIDE_I);
        serve(SIDE_I, 2, 3, {4{32'h5A5A0004}}, 1'b0);
        check("stretch_no_req_a", l2_read, 0);
        tick;
        check("stretch_no_req_b", l2_read, 0);
        tick;
        check("stretch_regrant", l2_read, 1);
        serve(SIDE_I, 1, 1, {4{32'h5A5A0005}}, 1'b1);
        repeat (3) tick;

        // Both sides request continuously: round-robin D,I,D,I...
        i_addr  = 28'h1111111;
        d_addr  = 28'h2222222;
        d_wdata = '0;
        i_read  = 1'b1;
        d_read  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            w = 32'hC0DE0000 + 32'(k);
            push_req((k % 2 == 0) ? SIDE_D : SIDE_I);
            serve((k % 2 == 0) ? SIDE_D : SIDE_I, 1 + k % 3, 1, {4{w}}, 1'b1);
            tick;
            if (k % 2 == 0) d_read = 1'b1;
            else            i_read = 1'b1;
        end
        i_read = 1'b0;
        d_read = 1'b0;
        repeat (3) tick;

        // Reset while a D read is outstanding.
        d_read = 1'b1;
        d_addr = 28'h0BADBAD;
        push_req(SIDE_D);
        n = 0;
        while (!l2_read && n < 20) begin
            tick;
            n++;
        end
        check("busy_before_reset", l2_read, 1);
        tick;
        reset  = 1'b0;
        d_read = 1'b0;
        tick;
        check("midrst_l2", {l2_read, l2_write}, 0);
        check("midrst_ready", {i_ready, d_ready}, 0);
        check("midrst_rdata", {i_rdata, d_rdata}, 0);
        reset    = 1'b1;
        l2_ready = 1'b1;
        repeat (2) tick;
        check("midrst_idle", {l2_read, i_ready, d_ready}, 0);
        l2_ready = 1'b0;
        tick;
        // last_grant cleared by reset, so D wins the next tie.
        i_read = 1'b1;
        i_addr = 28'h0777777;
        d_read = 1'b1;
        d_addr = 28'h0888888;
        push_req(SIDE_D);
        push_req(SIDE_I);
        serve(SIDE_D, 1, 1, {4{32'h66660006}}, 1'b1);
        serve(SIDE_I, 1, 1, {4{32'h77770007}}, 1'b1);
        repeat (3) tick;

        // Fixed-priority instance: both sides request, D wins all 8.
        d_addr     = 28'h3333333;
        d_wdata    = {4{32'hF00D0008}};
        fp_i_read  = 1'b1;
        fp_d_write = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (!(fp_l2_read | fp_l2_write) && n < 20) begin
                tick;
                n++;
            end
            check("fp_grant_d", {fp_l2_read, fp_l2_write, fp_l2_addr}, {2'b01, 28'h3333333});
            tick;
            fp_l2_ready = 1'b1;
            tick;
            check("fp_ready", {fp_i_ready, fp_d_ready}, 2'b01);
            fp_d_write  = 1'b0;
            fp_l2_ready = 1'b0;
            tick;
            fp_d_write = 1'b1;
        end
        fp_i_read  = 1'b0;
        fp_d_write = 1'b0;
        repeat (3) tick;

        check("req_q_empty", req_q.size(), 0);
        check("rsp_q_empty", rsp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
